// File: rtl/opentitan_soc_top.sv
// Loader/transmitter SoC block: words arrive over SPI or UART, are replayed on uart_tx,
// and a second UART receiver feeds gpio_o. Includes a divide-by-2 tempsense clock.

module opentitan_soc_top_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       i_en,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE} rx_state_e;

    rx_state_e        r_state;
    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_sh;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             w_rx;
    logic             w_full_tick;

    assign w_rx        = r_sync[1];
    assign w_full_tick = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign o_data      = r_data;
    assign o_valid     = r_valid;

    // 8N1 receiver: start validated at mid-bit, data sampled mid-bit LSB first
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= RX_IDLE;
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_sh    <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_rx};
            r_valid <= 1'b0;
            if (!i_en) begin
                r_state <= RX_IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    RX_IDLE: begin
                        r_cnt <= '0;
                        if (!w_rx) r_state <= RX_START;
                    end
                    RX_START: begin
                        if (r_cnt == CNT_W'(HALF - 1)) begin
                            r_cnt   <= '0;
                            r_bit   <= '0;
                            r_state <= w_rx ? RX_IDLE : RX_DATA;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    RX_DATA: begin
                        if (w_full_tick) begin
                            r_cnt <= '0;
                            r_sh  <= {w_rx, r_sh[7:1]};
                            if (r_bit == 3'd7) r_state <= RX_STOP;
                            else               r_bit   <= r_bit + 3'd1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    RX_STOP: begin
                        if (w_full_tick) begin
                            r_cnt <= '0;
                            if (w_rx) begin
                                r_data  <= r_sh;
                                r_valid <= 1'b1;
                                r_state <= RX_IDLE;
                            end else begin
                                r_state <= RX_WAIT_IDLE;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    // a framing error leaves the line low; wait for idle so it is not taken as a start
                    RX_WAIT_IDLE: if (w_rx) r_state <= RX_IDLE;
                    default:      r_state <= RX_IDLE;
                endcase
            end
        end
    end
endmodule

module opentitan_soc_top #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MEM_DEPTH    = 256,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       tempsense_clkref,
    output logic       tempsense_clkout,
    input  logic       sel,
    input  logic       spi_ss,
    input  logic       spi_mosi,
    input  logic       uart_rx_inst,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic       uart_txen,
    output logic [7:0] gpio_o
);
    localparam int unsigned AW     = $clog2(MEM_DEPTH);
    // one extra bit so the write pointer can rest at MEM_DEPTH
    localparam int unsigned PTR_W  = $clog2(MEM_DEPTH + 1);
    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned NBYTES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {PH_LOAD, PH_RUN, PH_DONE} phase_e;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

    logic [1:0]            r_rst_sync;
    logic                  w_rst_n;
    logic [1:0]            r_ts_rst;
    logic                  w_ts_rst_n;
    logic                  r_ts_div;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    phase_e                r_phase;
    tx_state_e             r_tx_state;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic                  r_wr_pend;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  w_wr_ok;
    logic                  w_load;

    logic [5:0]            r_spi_cnt;
    logic [DATA_WIDTH-1:0] r_spi_sh;
    logic                  r_spi_full;
    logic [1:0]            r_ld_bytes;
    logic [DATA_WIDTH-1:0] r_ld_word;

    logic [7:0]            w_inst_byte;
    logic                  w_inst_valid;
    logic [7:0]            w_dat_byte;
    logic                  w_dat_valid;
    logic [7:0]            r_rx_last;
    logic [7:0]            r_gpio;

    logic [CNT_W-1:0]      r_tx_cnt;
    logic [2:0]            r_tx_bit;
    logic [1:0]            r_tx_byte;
    logic [7:0]            r_tx_sh;
    logic [DATA_WIDTH-1:0] r_tx_word;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_tx_tick;
    logic                  r_uart_tx;
    logic                  r_uart_txen;

    // reset: asserts immediately, deasserts after two clk_i edges
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_rst_sync <= 2'b00;
        else         r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    always_ff @(posedge tempsense_clkref or negedge rst_ni) begin
        if (!rst_ni) r_ts_rst <= 2'b00;
        else         r_ts_rst <= {r_ts_rst[0], 1'b1};
    end
    assign w_ts_rst_n = r_ts_rst[1];

    always_ff @(posedge tempsense_clkref or negedge w_ts_rst_n) begin
        if (!w_ts_rst_n) r_ts_div <= 1'b0;
        else             r_ts_div <= ~r_ts_div;
    end
    assign tempsense_clkout = r_ts_div;

    assign w_load  = (r_phase == PH_LOAD);
    assign w_wr_ok = r_wr_pend && (r_wr_ptr < PTR_W'(MEM_DEPTH));

    opentitan_soc_top_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_inst (
        .clk_i   (clk_i),
        .rst_ni  (w_rst_n),
        .i_en    (w_load && sel),
        .i_rx    (uart_rx_inst),
        .o_data  (w_inst_byte),
        .o_valid (w_inst_valid)
    );

    opentitan_soc_top_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_dat (
        .clk_i   (clk_i),
        .rst_ni  (w_rst_n),
        .i_en    (1'b1),
        .i_rx    (uart_rx),
        .o_data  (w_dat_byte),
        .o_valid (w_dat_valid)
    );

    // SPI and UART loaders share one pending-write slot; sel makes them exclusive
    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr   <= '0;
            r_wr_pend  <= 1'b0;
            r_wr_data  <= '0;
            r_spi_cnt  <= '0;
            r_spi_sh   <= '0;
            r_spi_full <= 1'b0;
            r_ld_bytes <= '0;
            r_ld_word  <= '0;
        end else begin
            r_wr_pend <= 1'b0;
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);

            if (!w_load || sel || spi_ss) begin
                r_spi_cnt  <= '0;
                r_spi_full <= 1'b0;
            end else if (!r_spi_full) begin
                r_spi_sh <= {r_spi_sh[DATA_WIDTH-2:0], spi_mosi};
                if (r_spi_cnt == 6'(DATA_WIDTH - 1)) begin
                    r_wr_pend  <= 1'b1;
                    r_wr_data  <= {r_spi_sh[DATA_WIDTH-2:0], spi_mosi};
                    r_spi_full <= 1'b1;
                    r_spi_cnt  <= '0;
                end else begin
                    r_spi_cnt <= r_spi_cnt + 6'd1;
                end
            end

            if (!w_load || !sel) begin
                r_ld_bytes <= '0;
            end else if (w_inst_valid) begin
                r_ld_word <= {r_ld_word[DATA_WIDTH-9:0], w_inst_byte};
                if (r_ld_bytes == 2'(NBYTES - 1)) begin
                    r_wr_pend  <= 1'b1;
                    r_wr_data  <= {r_ld_word[DATA_WIDTH-9:0], w_inst_byte};
                    r_ld_bytes <= '0;
                end else begin
                    r_ld_bytes <= r_ld_bytes + 2'd1;
                end
            end
        end
    end

    // instruction memory is never reset
    always_ff @(posedge clk_i) begin
        if (w_wr_ok) r_mem[r_wr_ptr[AW-1:0]] <= r_wr_data;
    end
    assign w_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rx_last <= '0;
            r_gpio    <= '0;
        end else begin
            if (w_dat_valid) r_rx_last <= w_dat_byte;
            r_gpio <= w_load ? 8'(r_wr_ptr) : r_rx_last;
        end
    end
    assign gpio_o = r_gpio;

    assign w_tx_tick = (r_tx_cnt == CNT_W'(CLKS_PER_BIT - 1));

    // phase sequencing and word transmitter: 4 frames per word, MSB byte first
    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_phase     <= PH_LOAD;
            r_tx_state  <= TX_IDLE;
            r_rd_ptr    <= '0;
            r_tx_cnt    <= '0;
            r_tx_bit    <= '0;
            r_tx_byte   <= '0;
            r_tx_sh     <= '0;
            r_tx_word   <= '0;
            r_uart_tx   <= 1'b1;
            r_uart_txen <= 1'b0;
        end else begin
            case (r_phase)
                PH_LOAD: begin
                    if (en_i) begin
                        r_phase    <= PH_RUN;
                        r_rd_ptr   <= '0;
                        r_tx_state <= TX_IDLE;
                    end
                end
                PH_RUN: begin
                    case (r_tx_state)
                        TX_IDLE: begin
                            if (r_rd_ptr >= r_wr_ptr) begin
                                r_phase <= PH_DONE;
                            end else begin
                                r_tx_sh     <= w_rd_data[DATA_WIDTH-1 -: 8];
                                r_tx_word   <= w_rd_data << 8;
                                r_tx_byte   <= '0;
                                r_tx_cnt    <= '0;
                                r_uart_tx   <= 1'b0;
                                r_uart_txen <= 1'b1;
                                r_tx_state  <= TX_START;
                            end
                        end
                        TX_START: begin
                            if (w_tx_tick) begin
                                r_tx_cnt   <= '0;
                                r_tx_bit   <= '0;
                                r_uart_tx  <= r_tx_sh[0];
                                r_tx_sh    <= {1'b0, r_tx_sh[7:1]};
                                r_tx_state <= TX_DATA;
                            end else begin
                                r_tx_cnt <= r_tx_cnt + CNT_W'(1);
                            end
                        end
                        TX_DATA: begin
                            if (w_tx_tick) begin
                                r_tx_cnt <= '0;
                                if (r_tx_bit == 3'd7) begin
                                    r_uart_tx  <= 1'b1;
                                    r_tx_state <= TX_STOP;
                                end else begin
                                    r_uart_tx <= r_tx_sh[0];
                                    r_tx_sh   <= {1'b0, r_tx_sh[7:1]};
                                    r_tx_bit  <= r_tx_bit + 3'd1;
                                end
                            end else begin
                                r_tx_cnt <= r_tx_cnt + CNT_W'(1);
                            end
                        end
                        TX_STOP: begin
                            if (w_tx_tick) begin
                                r_tx_cnt <= '0;
                                if (r_tx_byte == 2'(NBYTES - 1)) begin
                                    r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
                                    r_uart_txen <= 1'b0;
                                    r_tx_state  <= TX_IDLE;
                                end else begin
                                    r_tx_byte  <= r_tx_byte + 2'd1;
                                    r_tx_sh    <= r_tx_word[DATA_WIDTH-1 -: 8];
                                    r_tx_word  <= r_tx_word << 8;
                                    r_uart_tx  <= 1'b0;
                                    r_tx_state <= TX_START;
                                end
                            end else begin
                                r_tx_cnt <= r_tx_cnt + CNT_W'(1);
                            end
                        end
                        default: r_tx_state <= TX_IDLE;
                    endcase
                end
                default: r_phase <= PH_DONE;
            endcase
        end
    end

    assign uart_tx   = r_uart_tx;
    assign uart_txen = r_uart_txen;
endmodule

// File: tb/tb_opentitan_soc_top.sv
// Directed bench for opentitan_soc_top: SPI/UART loading, word replay on uart_tx,
// data-path gpio, resets and the tempsense divider.

module tb_opentitan_soc_top;
    localparam int unsigned CPB = 16;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       en_i = 1'b0;
    logic       tempsense_clkref = 1'b0;
    logic       tempsense_clkout;
    logic       sel = 1'b0;
    logic       spi_ss = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       uart_rx_inst = 1'b1;
    logic       uart_rx = 1'b1;
    logic       uart_tx;
    logic       uart_txen;
    logic [7:0] gpio_o;

    int vecs = 0;
    int errs = 0;

    opentitan_soc_top #(.DATA_WIDTH(32), .MEM_DEPTH(256), .CLKS_PER_BIT(CPB)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .en_i             (en_i),
        .tempsense_clkref (tempsense_clkref),
        .tempsense_clkout (tempsense_clkout),
        .sel              (sel),
        .spi_ss           (spi_ss),
        .spi_mosi         (spi_mosi),
        .uart_rx_inst     (uart_rx_inst),
        .uart_rx          (uart_rx),
        .uart_tx          (uart_tx),
        .uart_txen        (uart_txen),
        .gpio_o           (gpio_o)
    );

    always #5 clk_i = ~clk_i;
    always #7 tempsense_clkref = ~tempsense_clkref;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_spi(input logic [31:0] w, input int nbits);
        @(negedge clk_i);
        spi_ss = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = (i < 32) ? w[31-i] : 1'b1;
            @(negedge clk_i);
        end
        spi_ss   = 1'b1;
        spi_mosi = 1'b0;
        repeat (4) @(negedge clk_i);
    endtask

    task automatic drive_line(input bit data_line, input logic v);
        if (data_line) uart_rx = v;
        else           uart_rx_inst = v;
    endtask

    task automatic send_uart(input bit data_line, input logic [7:0] b, input logic stop);
        @(negedge clk_i);
        drive_line(data_line, 1'b0);
        repeat (CPB) @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
            drive_line(data_line, b[i]);
            repeat (CPB) @(negedge clk_i);
        end
        drive_line(data_line, stop);
        repeat (CPB) @(negedge clk_i);
        drive_line(data_line, 1'b1);
        repeat (2 * CPB) @(negedge clk_i);
    endtask

    // decode one uart_tx frame; returns at the middle of the stop bit
    task automatic tx_byte(input string tag, input logic [7:0] exp);
        int n = 0;
        logic [7:0] b;
        while (uart_tx !== 1'b0 && n < 3000) begin
            @(negedge clk_i);
            n++;
        end
        chk({tag, "_start"}, 32'(uart_tx), 32'h0);
        repeat (CPB / 2 - 1) @(negedge clk_i);
        chk({tag, "_txen"}, 32'(uart_txen), 32'h1);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk_i);
            b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk_i);
        chk({tag, "_stop"}, 32'(uart_tx), 32'h1);
        chk({tag, "_data"}, 32'(b), 32'(exp));
    endtask

    task automatic watch_silent(input string tag, input int cycles);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_i);
            if (uart_txen !== 1'b0 || uart_tx !== 1'b1) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'h0);
    endtask

    initial begin
        logic [7:0] exp_bytes [8];
        exp_bytes[0] = 8'hDE; exp_bytes[1] = 8'hAD; exp_bytes[2] = 8'hBE; exp_bytes[3] = 8'hEF;
        exp_bytes[4] = 8'h00; exp_bytes[5] = 8'h00; exp_bytes[6] = 8'h00; exp_bytes[7] = 8'h5A;

        // reset state while both clocks run
        repeat (4) @(negedge clk_i);
        chk("rst_uart_tx", 32'(uart_tx), 32'h1);
        chk("rst_txen", 32'(uart_txen), 32'h0);
        chk("rst_gpio", 32'(gpio_o), 32'h0);
        chk("rst_ts_clkout", 32'(tempsense_clkout), 32'h0);

        // release away from a clkref edge: 2 sync edges, then toggles on the 3rd onward
        @(posedge tempsense_clkref);
        #3 rst_ni = 1'b1;
        repeat (3) @(posedge tempsense_clkref);
        #1 chk("ts_edge3", 32'(tempsense_clkout), 32'h1);
        @(posedge tempsense_clkref);
        #1 chk("ts_edge4", 32'(tempsense_clkout), 32'h0);
        @(posedge tempsense_clkref);
        #1 chk("ts_edge5", 32'(tempsense_clkout), 32'h1);
        repeat (4) @(negedge clk_i);
        chk("load_gpio0", 32'(gpio_o), 32'h0);

        // SPI load; second word carries extra bits that must be ignored
        sel = 1'b0;
        send_spi(32'hDEADBEEF, 32);
        chk("spi_w1_gpio", 32'(gpio_o), 32'h1);
        send_spi(32'h0000005A, 36);
        chk("spi_w2_gpio", 32'(gpio_o), 32'h2);

        // run: replay both words
        en_i = 1'b1;
        for (int i = 0; i < 8; i++) tx_byte($sformatf("run_b%0d", i), exp_bytes[i]);
        repeat (CPB) @(negedge clk_i);
        en_i = 1'b0;
        watch_silent("done_silent", 400);

        // data path in DONE, including a framing error and recovery
        send_uart(1'b1, 8'hA5, 1'b1);
        chk("dp_a5", 32'(gpio_o), 32'hA5);
        send_uart(1'b1, 8'h3C, 1'b0);
        chk("dp_badstop", 32'(gpio_o), 32'hA5);
        send_uart(1'b1, 8'h5A, 1'b1);
        chk("dp_recover", 32'(gpio_o), 32'h5A);

        // abort a partial SPI word, then load a full one
        rst_ni = 1'b0;
        #1 chk("rst2_gpio", 32'(gpio_o), 32'h0);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (4) @(negedge clk_i);
        send_spi(32'hFFFFFFFF, 20);
        chk("abort_gpio", 32'(gpio_o), 32'h0);
        send_spi(32'h12345678, 32);
        chk("abort_full_gpio", 32'(gpio_o), 32'h1);
        en_i = 1'b1;
        tx_byte("abort_b0", 8'h12);
        tx_byte("abort_b1", 8'h34);
        tx_byte("abort_b2", 8'h56);
        tx_byte("abort_b3", 8'h78);
        repeat (CPB) @(negedge clk_i);
        en_i = 1'b0;
        watch_silent("abort_done_silent", 200);

        // UART load; SPI traffic is ignored while sel=1
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (4) @(negedge clk_i);
        sel = 1'b1;
        send_spi(32'hCAFEF00D, 32);
        chk("sel_spi_ignored", 32'(gpio_o), 32'h0);
        send_uart(1'b0, 8'h01, 1'b1);
        send_uart(1'b0, 8'h02, 1'b1);
        send_uart(1'b0, 8'h03, 1'b1);
        send_uart(1'b0, 8'h04, 1'b1);
        chk("uload_gpio", 32'(gpio_o), 32'h1);
        send_uart(1'b1, 8'h3C, 1'b1);
        chk("uload_gpio_ptr", 32'(gpio_o), 32'h1);
        en_i = 1'b1;
        tx_byte("uload_b0", 8'h01);
        chk("run_gpio_rx", 32'(gpio_o), 32'h3C);

        // reset in the middle of the second frame
        begin
            int n = 0;
            while (uart_tx !== 1'b0 && n < 3000) begin
                @(negedge clk_i);
                n++;
            end
        end
        repeat (40) @(negedge clk_i);
        chk("midrun_txen", 32'(uart_txen), 32'h1);
        rst_ni = 1'b0;
        #1;
        chk("midrun_rst_tx", 32'(uart_tx), 32'h1);
        chk("midrun_rst_txen", 32'(uart_txen), 32'h0);
        chk("midrun_rst_gpio", 32'(gpio_o), 32'h0);
        en_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        watch_silent("post_rst_silent", 600);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
